// File: rtl/alu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_pkg : shared widths, ALU unit-class codes and sequencer state encoding
// Revision: 1.0
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int CTRL_W  = 3;
    localparam int SHAMT_W = 5;

    localparam logic [CTRL_W-1:0] ALU_ADDSUB = 3'b000;
    localparam logic [CTRL_W-1:0] ALU_SET    = 3'b001;
    localparam logic [CTRL_W-1:0] ALU_LOGIC  = 3'b010;
    localparam logic [CTRL_W-1:0] ALU_SHIFT  = 3'b011;
    localparam logic [CTRL_W-1:0] ALU_BRANCH = 3'b100;
    localparam logic [CTRL_W-1:0] ALU_IDLE   = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_STEP = 3'd2,
        ST_CAPT = 3'd3,
        ST_RESP = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_seq_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_seq_ctrl_if : request/response handshake between issue logic and ALU sequencer
// Revision: 1.0
// ---------------------------------------------------------------------------
interface alu_seq_ctrl_if;
    import alu_pkg::*;

    logic               req_valid;
    logic               req_ready;
    logic [CTRL_W-1:0]  req_ctrl;
    logic [SHAMT_W-1:0] req_shamt;
    logic               res_valid;
    logic               res_err;
    logic               res_ready;

    modport master (
        output req_valid, req_ctrl, req_shamt, res_ready,
        input  req_ready, res_valid, res_err
    );

    modport slave (
        input  req_valid, req_ctrl, req_shamt, res_ready,
        output req_ready, res_valid, res_err
    );

endinterface
`default_nettype wire

// File: rtl/alu_step_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_step_counter : loadable down-counter with zero and last-step flags
// Revision: 1.0
// ---------------------------------------------------------------------------
module alu_step_counter #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero,
    output logic             last
);

    logic [WIDTH-1:0] r_count;

    // clear wins over load so an abort never leaves a stale count behind
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero = (r_count == '0);
    assign last = (r_count == {{(WIDTH-1){1'b0}}, 1'b1});

endmodule
`default_nettype wire

// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_seq_ctrl : ALU execution-stage sequencer (unit select, shifter steps, result capture)
// Revision: 1.0
// ---------------------------------------------------------------------------
module alu_seq_ctrl
    import alu_pkg::*;
(
    input  logic                CLK,
    input  logic                rst_n,
    alu_seq_ctrl_if.slave       bus,
    input  logic                flush,
    output logic [CTRL_W-1:0]   alu_ctrl,
    output logic                shift_load,
    output logic                shift_step,
    output logic                res_capture,
    output logic                busy
);

    state_t             r_state;
    state_t             w_next_state;
    logic [CTRL_W-1:0]  r_ctrl;
    logic               r_err;
    logic               w_accept;
    logic               w_cnt_zero;
    logic               w_cnt_last;

    // a new request may overlap the response handshake, but never a flush
    assign bus.req_ready = ((r_state == ST_IDLE) ||
                            ((r_state == ST_RESP) && bus.res_ready)) && !flush;
    assign w_accept      = bus.req_valid && bus.req_ready;

    alu_step_counter #(
        .WIDTH      (SHAMT_W)
    ) u_step_counter (
        .clk        (CLK),
        .rst_n      (rst_n),
        .clear      (flush),
        .load       (w_accept),
        .load_value (bus.req_shamt),
        .dec        (r_state == ST_STEP),
        .zero       (w_cnt_zero),
        .last       (w_cnt_last)
    );

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ctrl  <= ALU_IDLE;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_ctrl <= bus.req_ctrl;
                r_err  <= (bus.req_ctrl > ALU_BRANCH);
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        w_next_state = (bus.req_ctrl == ALU_SHIFT) ? ST_LOAD : ST_CAPT;
                    end
                end
                ST_LOAD: w_next_state = w_cnt_zero ? ST_CAPT : ST_STEP;
                ST_STEP: w_next_state = w_cnt_last ? ST_CAPT : ST_STEP;
                ST_CAPT: w_next_state = ST_RESP;
                ST_RESP: begin
                    if (w_accept) begin
                        w_next_state = (bus.req_ctrl == ALU_SHIFT) ? ST_LOAD : ST_CAPT;
                    end else if (bus.res_ready) begin
                        w_next_state = ST_IDLE;
                    end
                end
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    // illegal codes still pass through CAPT so their response keeps fixed latency
    always_comb begin
        alu_ctrl    = ALU_IDLE;
        shift_load  = 1'b0;
        shift_step  = 1'b0;
        res_capture = 1'b0;
        unique case (r_state)
            ST_LOAD: begin
                alu_ctrl   = ALU_SHIFT;
                shift_load = 1'b1;
            end
            ST_STEP: begin
                alu_ctrl   = ALU_SHIFT;
                shift_step = 1'b1;
            end
            ST_CAPT: begin
                alu_ctrl    = r_err ? ALU_IDLE : r_ctrl;
                res_capture = !r_err;
            end
            default: ;
        endcase
    end

    assign bus.res_valid = (r_state == ST_RESP);
    assign bus.res_err   = (r_state == ST_RESP) && r_err;
    assign busy          = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_alu_seq_ctrl : scoreboard bench for the ALU sequencing controller
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_alu_seq_ctrl;
    import alu_pkg::*;

    logic               CLK   = 1'b0;
    logic               rst_n = 1'b0;
    logic               flush = 1'b0;
    logic [CTRL_W-1:0]  alu_ctrl;
    logic               shift_load;
    logic               shift_step;
    logic               res_capture;
    logic               busy;

    alu_seq_ctrl_if bus ();

    alu_seq_ctrl dut (
        .CLK         (CLK),
        .rst_n       (rst_n),
        .bus         (bus),
        .flush       (flush),
        .alu_ctrl    (alu_ctrl),
        .shift_load  (shift_load),
        .shift_step  (shift_step),
        .res_capture (res_capture),
        .busy        (busy)
    );

    always #5 CLK = ~CLK;

    int   checks = 0;
    int   errors = 0;
    logic exp_q[$];

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // expected res_err pushed at accept, popped at response handshake; flush discards
    always @(negedge CLK) begin
        if (rst_n) begin
            if (flush && busy) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end else begin
                if (bus.req_valid && bus.req_ready)
                    exp_q.push_back(bus.req_ctrl > ALU_BRANCH);
                if (bus.res_valid && bus.res_ready) begin
                    if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
                    else chk("sb_res_err", int'(bus.res_err), int'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic run_op(input logic [2:0] ctrl, input logic [4:0] shamt);
        int         lat   = 0;
        int         loads = 0;
        int         steps = 0;
        int         caps  = 0;
        int         bad   = 0;
        logic [2:0] prev  = 3'b111;
        logic [2:0] capt  = 3'b000;
        bit         sh;
        bit         il;
        sh = (ctrl == ALU_SHIFT);
        il = (ctrl > ALU_BRANCH);
        chk("op_pre_ready", int'(bus.req_ready), 1);
        bus.req_valid = 1'b1;
        bus.req_ctrl  = ctrl;
        bus.req_shamt = shamt;
        bus.res_ready = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            if (shift_load) loads++;
            if (shift_step) begin
                steps++;
                if (alu_ctrl != ALU_SHIFT) bad++;
            end
            if (res_capture) caps++;
            if (bus.res_valid) begin
                lat  = c;
                capt = prev;
                break;
            end
            prev = alu_ctrl;
            tick();
        end
        chk("op_latency", lat, sh ? 3 + int'(shamt) : 2);
        chk("op_loads", loads, sh ? 1 : 0);
        chk("op_steps", steps, sh ? int'(shamt) : 0);
        chk("op_step_ctrl", bad, 0);
        chk("op_captures", caps, il ? 0 : 1);
        chk("op_capt_ctrl", int'(capt), il ? 7 : int'(ctrl));
        tick();
        chk("op_idle_busy", int'(busy), 0);
        chk("op_idle_valid", int'(bus.res_valid), 0);
    endtask

    initial begin
        int nvalid;
        bus.req_valid = 1'b0;
        bus.req_ctrl  = 3'b000;
        bus.req_shamt = 5'd0;
        bus.res_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst_req_ready", int'(bus.req_ready), 1);
        chk("rst_alu_ctrl", int'(alu_ctrl), 7);
        chk("rst_busy", int'(busy), 0);
        chk("rst_res_valid", int'(bus.res_valid), 0);
        chk("rst_capture", int'(res_capture), 0);

        // back-to-back: second request accepted during the first response
        bus.req_valid = 1'b1;
        bus.req_ctrl  = ALU_ADDSUB;
        tick();
        bus.req_ctrl  = ALU_LOGIC;
        chk("b2b_capt_ctrl", int'(alu_ctrl), 0);
        chk("b2b_capture", int'(res_capture), 1);
        chk("b2b_ready_capt", int'(bus.req_ready), 0);
        tick();
        chk("b2b_res_valid", int'(bus.res_valid), 1);
        chk("b2b_res_err", int'(bus.res_err), 0);
        chk("b2b_ready_resp", int'(bus.req_ready), 1);
        tick();
        bus.req_valid = 1'b0;
        chk("b2b2_capt_ctrl", int'(alu_ctrl), 2);
        chk("b2b2_capture", int'(res_capture), 1);
        chk("b2b2_res_valid", int'(bus.res_valid), 0);
        tick();
        chk("b2b2_res_valid", int'(bus.res_valid), 1);
        tick();
        chk("b2b_idle", int'(busy), 0);

        run_op(ALU_SHIFT, 5'd5);
        run_op(ALU_SHIFT, 5'd0);
        run_op(ALU_SHIFT, 5'd31);
        run_op(3'b110, 5'd0);
        run_op(ALU_BRANCH, 5'd0);
        run_op(ALU_SET, 5'd0);
        run_op(3'b111, 5'd3);
        run_op(ALU_LOGIC, 5'd9);

        // response stall: requests ignored while res_ready is low
        bus.res_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_ctrl  = ALU_SET;
        tick();
        bus.req_ctrl  = ALU_ADDSUB;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("stall_valid", int'(bus.res_valid), 1);
            chk("stall_ready", int'(bus.req_ready), 0);
            tick();
        end
        bus.req_valid = 1'b0;
        bus.res_ready = 1'b1;
        #1;
        chk("stall_release_valid", int'(bus.res_valid), 1);
        tick();
        chk("stall_done_busy", int'(busy), 0);
        chk("stall_done_valid", int'(bus.res_valid), 0);

        // flush during the third shift step with a competing request
        bus.req_valid = 1'b1;
        bus.req_ctrl  = ALU_SHIFT;
        bus.req_shamt = 5'd10;
        tick();
        bus.req_valid = 1'b0;
        nvalid = 0;
        for (int c = 0; c < 50; c++) begin
            if (shift_step) nvalid++;
            if (nvalid == 3) break;
            tick();
        end
        chk("flush_reach_step3", nvalid, 3);
        flush         = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_ctrl  = ALU_ADDSUB;
        #1;
        chk("flush_req_ready", int'(bus.req_ready), 0);
        tick();
        flush         = 1'b0;
        bus.req_valid = 1'b0;
        chk("flush_step", int'(shift_step), 0);
        chk("flush_busy", int'(busy), 0);
        chk("flush_alu_ctrl", int'(alu_ctrl), 7);
        nvalid = 0;
        for (int c = 0; c < 12; c++) begin
            if (bus.res_valid) nvalid++;
            tick();
        end
        chk("flush_no_result", nvalid, 0);

        // asynchronous reset mid-shift
        bus.req_valid = 1'b1;
        bus.req_ctrl  = ALU_SHIFT;
        bus.req_shamt = 5'd10;
        tick();
        bus.req_valid = 1'b0;
        tick();
        tick();
        chk("arst_pre_step", int'(shift_step), 1);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("arst_step", int'(shift_step), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_alu_ctrl", int'(alu_ctrl), 7);
        chk("arst_req_ready", int'(bus.req_ready), 1);
        chk("arst_res_valid", int'(bus.res_valid), 0);
        @(negedge CLK);
        rst_n = 1'b1;
        tick();
        chk("arst_after_busy", int'(busy), 0);
        run_op(ALU_ADDSUB, 5'd0);

        tick();
        chk("sb_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
